atm_core_multi: RTL and testbench
=================================

// Module: atm_core_multi
// PURPOSE
//   Parametrised successor of the single-session ATM controller. Serves NUM_ACCOUNTS accounts
//   through a req/done handshake and authenticates every transaction against a per-account PIN.
//   Adds per-account wrong-PIN lockout, overdraft and overflow protection, and error codes.
//   Sits between the keypad/card front-end and the display/cash-dispense logic.
// PARAMETERS
//   NUM_ACCOUNTS  8      number of accounts held in the bank (2..2**ACC_W)
//   ACC_W         3      account-number width
//   PIN_W         16     PIN width
//   AMT_W         32     amount and balance width (unsigned)
//   INIT_BAL      1000   reset balance of every account
//   INIT_PIN      1234   reset PIN of account 0; account i resets to INIT_PIN + i*PIN_STEP
//   PIN_STEP      1111   PIN increment per account index
//   MAX_TRIES     3      consecutive wrong PINs before an account locks
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active low
//   req        in   1      request strobe; sampled only while ready=1
//   ready      out  1      1 in IDLE, otherwise 0
//   operation  in   3      3=balance 4=withdraw 5=deposit 6=change PIN; other codes are invalid
//   acc_num    in   ACC_W  account index
//   pin        in   PIN_W  entered PIN
//   newPin     in   PIN_W  replacement PIN (operation 6)
//   amount     in   AMT_W  transaction amount (operations 4 and 5)
//   language   in   1      display language; latched with req
//   lang_sel   out  1      language latched at the last accepted req
//   done       out  1      1-cycle pulse at the end of every accepted request
//   success    out  1      result of the last request; valid from done, held until the next done
//   err_code   out  3      0 OK, 1 BADACC, 2 LOCKED, 3 BADPIN, 4 FUNDS, 5 OVF, 6 BADOP, 7 ZEROAMT
//   balance    out  AMT_W  post-transaction balance of the addressed account; 0 on any error
//   locked     out  1      addressed account is locked (valid with done)
//   state      out  3      FSM state encoding
// BEHAVIOUR
//   Reset (rst=0, async):
//     - state=7 (IDLE); all outputs 0 except ready=1.
//     - Every account restored: balance INIT_BAL, reset PIN, fail count 0, unlocked.
//     - Reset mid-transaction aborts the transaction without any account write or done pulse.
//   FSM (3-bit):
//     - IDLE(7) -> AUTH(1) on req&ready. The same edge latches operation, acc_num, pin, newPin,
//       amount and language.
//     - AUTH(1), checks in priority order:
//         acc_num>=NUM_ACCOUNTS -> BADACC
//         account locked -> LOCKED
//         pin mismatch -> BADPIN; fail count +1, and the account locks when the count reaches MAX_TRIES
//         operation invalid -> BADOP
//       Pass -> fail count cleared, go to the operation state (3 BAL, 4 WDR, 5 DEP, 6 CHPIN).
//       Any error -> go to RESP(0).
//     - BAL(3): no write.
//     - WDR(4): amount==0 -> ZEROAMT; amount>balance -> FUNDS; otherwise balance-=amount.
//     - DEP(5): amount==0 -> ZEROAMT; carry out of AMT_W -> OVF; otherwise balance+=amount.
//     - CHPIN(6): PIN replaced with newPin; balance reported unchanged.
//     - Error checks leave the account unchanged.
//     - Each operation state lasts 1 cycle -> RESP(0). RESP asserts done, drives the outputs, -> IDLE.
//   Latency: req edge to done = 3 cycles on success, 2 cycles on an AUTH error.
//     ready returns 1 the cycle after done.
//   Rules:
//     - req while ready=0 is ignored (no queueing).
//     - Inputs are don't-care after latching.
//     - balance output exactly equals the account's stored value after the write.
//     - The write path is single-ported: one account update per transaction.
//     - A locked account stays locked until reset.
//     - balance==amount on withdraw is allowed and leaves 0.
// STRUCTURE
//   - Shared package atm_pkg: operation codes, state encodings, err_code values, AMT/PIN typedefs.
//   - Sub-module atm_account_bank: per-account balance, PIN, fail-count and lock registers.
//     One combinational read port indexed by acc_num, one synchronous write port (we, idx,
//     bal_d, pin_d, fail_d, lock_d), async active-low reset to the parametrised init values.
//   - atm_core_multi holds the FSM, the request latch and the arithmetic with carry/borrow detect.
// TESTING
//   1. Reset, then req op=3 acc=1 pin=2345 -> done 3 cycles later; success=1 err=0 balance=1000;
//      state passes 1,3,0,7.
//   2. Op=5 acc=1 pin=2345 amount=1000 -> balance=2000.
//      Then op=4 amount=2001 -> err=4 FUNDS, balance kept at 2000 (check with op=3).
//   3. Op=3 acc=0 pin=1111 three times -> err=3,3,3, locked=1 on the third.
//      Then pin=1234 -> err=2 LOCKED. After reset the same request succeeds.
//   4. Op=6 acc=2 pin=3456 newPin=9999 -> success. pin=3456 -> err=3; pin=9999 -> success.
//   5. Op=5 acc=3 amount=32'hFFFF_FFFF -> err=5 OVF, balance unchanged at 1000.
//      acc=7 but NUM_ACCOUNTS=6 -> err=1. op=2 -> err=6.
//   6. Drive rst=0 in the WDR cycle of a 500 withdraw -> no done.
//      After release, op=3 returns balance=1000. req during a busy cycle -> ignored, one done only.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared types for the multi-account ATM core:
// FSM states, operation codes, error codes and data typedefs.
package atm_pkg;

  localparam int AMT_W_DEF = 32;
  localparam int PIN_W_DEF = 16;

  typedef logic [AMT_W_DEF-1:0] amt_t;
  typedef logic [PIN_W_DEF-1:0] pin_t;

  typedef enum logic [2:0] {
    S_RESP  = 3'd0,
    S_AUTH  = 3'd1,
    S_BAL   = 3'd3,
    S_WDR   = 3'd4,
    S_DEP   = 3'd5,
    S_CHPIN = 3'd6,
    S_IDLE  = 3'd7
  } state_t;

  localparam logic [2:0] OP_BAL   = 3'd3;
  localparam logic [2:0] OP_WDR   = 3'd4;
  localparam logic [2:0] OP_DEP   = 3'd5;
  localparam logic [2:0] OP_CHPIN = 3'd6;

  typedef enum logic [2:0] {
    E_OK      = 3'd0,
    E_BADACC  = 3'd1,
    E_LOCKED  = 3'd2,
    E_BADPIN  = 3'd3,
    E_FUNDS   = 3'd4,
    E_OVF     = 3'd5,
    E_BADOP   = 3'd6,
    E_ZEROAMT = 3'd7
  } err_t;

  function automatic logic op_valid(logic [2:0] op);
    return (op == OP_BAL) || (op == OP_WDR) ||
           (op == OP_DEP) || (op == OP_CHPIN);
  endfunction

endpackage

// File: rtl/atm_account_bank.sv
// Per-account balance/PIN/fail-count/lock registers.
// Ports: comb read at idx; sync write (we) at idx; async low reset.
module atm_account_bank
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 8,
  parameter int ACC_W        = 3,
  parameter int PIN_W        = 16,
  parameter int AMT_W        = 32,
  parameter int FAIL_W       = 2,
  parameter int INIT_BAL     = 1000,
  parameter int INIT_PIN     = 1234,
  parameter int PIN_STEP     = 1111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ACC_W-1:0]  idx,
  output logic [AMT_W-1:0]  rd_bal,
  output logic [PIN_W-1:0]  rd_pin,
  output logic [FAIL_W-1:0] rd_fail,
  output logic              rd_lock,
  input  logic              we,
  input  logic [AMT_W-1:0]  bal_d,
  input  logic [PIN_W-1:0]  pin_d,
  input  logic [FAIL_W-1:0] fail_d,
  input  logic              lock_d
);

  logic [AMT_W-1:0]  bal_q  [NUM_ACCOUNTS];
  logic [PIN_W-1:0]  pin_q  [NUM_ACCOUNTS];
  logic [FAIL_W-1:0] fail_q [NUM_ACCOUNTS];
  logic              lock_q [NUM_ACCOUNTS];
  logic              in_range;

  assign in_range = {1'b0, idx} < (ACC_W+1)'(NUM_ACCOUNTS);

  // Out-of-range indices read as an empty, unlocked account.
  always_comb begin
    rd_bal  = '0;
    rd_pin  = '0;
    rd_fail = '0;
    rd_lock = 1'b0;
    if (in_range) begin
      rd_bal  = bal_q[idx];
      rd_pin  = pin_q[idx];
      rd_fail = fail_q[idx];
      rd_lock = lock_q[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal_q[i]  <= AMT_W'(INIT_BAL);
        pin_q[i]  <= PIN_W'(INIT_PIN + i * PIN_STEP);
        fail_q[i] <= '0;
        lock_q[i] <= 1'b0;
      end
    end else if (we && in_range) begin
      bal_q[idx]  <= bal_d;
      pin_q[idx]  <= pin_d;
      fail_q[idx] <= fail_d;
      lock_q[idx] <= lock_d;
    end
  end

endmodule

// File: rtl/atm_core_multi.sv
// Multi-account ATM controller: req/done handshake, PIN auth,
// lockout, overdraft/overflow checks; bank held in atm_account_bank.
module atm_core_multi
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 8,
  parameter int ACC_W        = 3,
  parameter int PIN_W        = 16,
  parameter int AMT_W        = 32,
  parameter int INIT_BAL     = 1000,
  parameter int INIT_PIN     = 1234,
  parameter int PIN_STEP     = 1111,
  parameter int MAX_TRIES    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             ready,
  input  logic [2:0]       operation,
  input  logic [ACC_W-1:0] acc_num,
  input  logic [PIN_W-1:0] pin,
  input  logic [PIN_W-1:0] newPin,
  input  logic [AMT_W-1:0] amount,
  input  logic             language,
  output logic             lang_sel,
  output logic             done,
  output logic             success,
  output logic [2:0]       err_code,
  output logic [AMT_W-1:0] balance,
  output logic             locked,
  output logic [2:0]       state
);

  localparam int FAIL_W = $clog2(MAX_TRIES + 1);

  state_t           st_q;
  logic [2:0]       op_q;
  logic [ACC_W-1:0] acc_q;
  logic [PIN_W-1:0] pin_q;
  logic [PIN_W-1:0] npin_q;
  logic [AMT_W-1:0] amt_q;

  logic [AMT_W-1:0]  rd_bal;
  logic [PIN_W-1:0]  rd_pin;
  logic [FAIL_W-1:0] rd_fail;
  logic              rd_lock;
  logic              we;
  logic [AMT_W-1:0]  bal_d;
  logic [PIN_W-1:0]  pin_d;
  logic [FAIL_W-1:0] fail_d;
  logic              lock_d;

  logic              acc_ok;
  err_t              auth_err;
  err_t              op_err;
  logic [FAIL_W-1:0] fail_inc;
  logic              hit_max;
  logic [AMT_W:0]    sum;

  assign ready  = (st_q == S_IDLE);
  assign state  = st_q;
  assign acc_ok = {1'b0, acc_q} < (ACC_W+1)'(NUM_ACCOUNTS);
  assign sum    = {1'b0, rd_bal} + {1'b0, amt_q};
  assign fail_inc = rd_fail + 1'b1;
  assign hit_max  = (fail_inc == FAIL_W'(MAX_TRIES));

  always_comb begin
    auth_err = E_OK;
    if (!acc_ok)               auth_err = E_BADACC;
    else if (rd_lock)          auth_err = E_LOCKED;
    else if (pin_q != rd_pin)  auth_err = E_BADPIN;
    else if (!op_valid(op_q))  auth_err = E_BADOP;
  end

  always_comb begin
    op_err = E_OK;
    bal_d  = rd_bal;
    pin_d  = rd_pin;
    unique case (st_q)
      S_WDR: begin
        if (amt_q == '0)         op_err = E_ZEROAMT;
        else if (amt_q > rd_bal) op_err = E_FUNDS;
        else                     bal_d  = rd_bal - amt_q;
      end
      S_DEP: begin
        if (amt_q == '0)   op_err = E_ZEROAMT;
        else if (sum[AMT_W]) op_err = E_OVF;
        else               bal_d  = sum[AMT_W-1:0];
      end
      S_CHPIN: pin_d = npin_q;
      default: ;
    endcase
  end

  // One write per transaction: a wrong PIN bumps the fail count in
  // AUTH; otherwise the op state writes back with the count cleared.
  always_comb begin
    we     = 1'b0;
    fail_d = rd_fail;
    lock_d = rd_lock;
    unique case (st_q)
      S_AUTH: begin
        if (auth_err == E_BADPIN) begin
          we     = 1'b1;
          fail_d = fail_inc;
          lock_d = hit_max;
        end
      end
      S_BAL, S_WDR, S_DEP, S_CHPIN: begin
        we     = 1'b1;
        fail_d = '0;
        lock_d = 1'b0;
      end
      default: ;
    endcase
  end

  atm_account_bank #(
    .NUM_ACCOUNTS(NUM_ACCOUNTS), .ACC_W(ACC_W),
    .PIN_W(PIN_W), .AMT_W(AMT_W), .FAIL_W(FAIL_W),
    .INIT_BAL(INIT_BAL), .INIT_PIN(INIT_PIN),
    .PIN_STEP(PIN_STEP)
  ) u_bank (
    .clk(clk), .rst_n(rst), .idx(acc_q),
    .rd_bal(rd_bal), .rd_pin(rd_pin),
    .rd_fail(rd_fail), .rd_lock(rd_lock),
    .we(we), .bal_d(bal_d), .pin_d(pin_d),
    .fail_d(fail_d), .lock_d(lock_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= S_IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      pin_q    <= '0;
      npin_q   <= '0;
      amt_q    <= '0;
      lang_sel <= 1'b0;
      done     <= 1'b0;
      success  <= 1'b0;
      err_code <= '0;
      balance  <= '0;
      locked   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st_q)
        S_IDLE: begin
          if (req) begin
            op_q     <= operation;
            acc_q    <= acc_num;
            pin_q    <= pin;
            npin_q   <= newPin;
            amt_q    <= amount;
            lang_sel <= language;
            st_q     <= S_AUTH;
          end
        end
        S_AUTH: begin
          if (auth_err != E_OK) begin
            st_q     <= S_RESP;
            done     <= 1'b1;
            success  <= 1'b0;
            err_code <= auth_err;
            balance  <= '0;
            locked   <= (auth_err == E_LOCKED) ||
                        ((auth_err == E_BADPIN) && hit_max);
          end else begin
            st_q <= state_t'(op_q);
          end
        end
        S_BAL, S_WDR, S_DEP, S_CHPIN: begin
          st_q     <= S_RESP;
          done     <= 1'b1;
          success  <= (op_err == E_OK);
          err_code <= op_err;
          balance  <= (op_err == E_OK) ? bal_d : '0;
          locked   <= 1'b0;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_core_multi.sv
// Self-checking bench for atm_core_multi (NUM_ACCOUNTS=6):
// vector table through a scoreboard plus multi-cycle corner sequences.
module tb_atm_core_multi;

  logic        clk;
  logic        rst;
  logic        req;
  logic        ready;
  logic [2:0]  operation;
  logic [2:0]  acc_num;
  logic [15:0] pin;
  logic [15:0] newPin;
  logic [31:0] amount;
  logic        language;
  logic        lang_sel;
  logic        done;
  logic        success;
  logic [2:0]  err_code;
  logic [31:0] balance;
  logic        locked;
  logic [2:0]  state;

  atm_core_multi #(.NUM_ACCOUNTS(6)) dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready),
    .operation(operation), .acc_num(acc_num), .pin(pin),
    .newPin(newPin), .amount(amount), .language(language),
    .lang_sel(lang_sel), .done(done), .success(success),
    .err_code(err_code), .balance(balance), .locked(locked),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  acc;
    logic [15:0] pin;
    logic [15:0] npin;
    logic [31:0] amt;
    logic        succ;
    logic [2:0]  err;
    logic [31:0] bal;
    logic        lck;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[24];
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  function automatic vec_t mk(int op, int acc, int p, int np,
                              int amt, int s, int e, int b, int l);
    vec_t v;
    v.op = 3'(op); v.acc = 3'(acc); v.pin = 16'(p);
    v.npin = 16'(np); v.amt = 32'(amt); v.succ = 1'(s);
    v.err = 3'(e); v.bal = 32'(b); v.lck = 1'(l);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v, logic lang);
    operation = v.op; acc_num = v.acc; pin = v.pin;
    newPin = v.npin; amount = v.amt; language = lang;
    req = 1'b1;
    sb.push_back(v);
  endtask

  task automatic scramble();
    operation = 3'($urandom); acc_num = 3'($urandom);
    pin = 16'($urandom); newPin = 16'($urandom);
    amount = $urandom; language = 1'($urandom);
  endtask

  task automatic compare_done(string tag);
    vec_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_success"}, 32'(success), 32'(e.succ));
    chk({tag, "_err"}, 32'(err_code), 32'(e.err));
    chk({tag, "_bal"}, balance, e.bal);
    chk({tag, "_locked"}, 32'(locked), 32'(e.lck));
  endtask

  task automatic wait_done(string tag, output int lat);
    bit seen;
    seen = 0;
    lat = 1;
    while (!seen && lat < 12) begin
      if (done) seen = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    if (seen) compare_done(tag);
    else if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic run(vec_t v, string tag);
    int lat;
    int exp_lat;
    @(negedge clk);
    drive(v, 1'b0);
    @(negedge clk);
    req = 1'b0;
    scramble();
    exp_lat = (v.err inside {3'd1, 3'd2, 3'd3, 3'd6}) ? 2 : 3;
    wait_done(tag, lat);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
    chk({tag, "_ready"}, 32'(ready), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [2:0] st [4];
    int d0;
    int lat;

    rst = 1'b0; req = 1'b0; operation = '0; acc_num = '0;
    pin = '0; newPin = '0; amount = '0; language = 1'b0;

    tbl[0]  = mk(3, 1, 2345, 0, 0,          1, 0, 1000, 0);
    tbl[1]  = mk(5, 1, 2345, 0, 1000,       1, 0, 2000, 0);
    tbl[2]  = mk(4, 1, 2345, 0, 2001,       0, 4, 0,    0);
    tbl[3]  = mk(3, 1, 2345, 0, 0,          1, 0, 2000, 0);
    tbl[4]  = mk(4, 1, 2345, 0, 2000,       1, 0, 0,    0);
    tbl[5]  = mk(5, 1, 2345, 0, 0,          0, 7, 0,    0);
    tbl[6]  = mk(6, 2, 3456, 9999, 0,       1, 0, 1000, 0);
    tbl[7]  = mk(3, 2, 3456, 0, 0,          0, 3, 0,    0);
    tbl[8]  = mk(3, 2, 9999, 0, 0,          1, 0, 1000, 0);
    tbl[9]  = mk(5, 3, 4567, 0, 32'hFFFF_FFFF, 0, 5, 0, 0);
    tbl[10] = mk(3, 3, 4567, 0, 0,          1, 0, 1000, 0);
    tbl[11] = mk(3, 7, 4567, 0, 0,          0, 1, 0,    0);
    tbl[12] = mk(2, 3, 4567, 0, 0,          0, 6, 0,    0);
    tbl[13] = mk(3, 0, 1111, 0, 0,          0, 3, 0,    0);
    tbl[14] = mk(3, 0, 1111, 0, 0,          0, 3, 0,    0);
    tbl[15] = mk(3, 0, 1111, 0, 0,          0, 3, 0,    1);
    tbl[16] = mk(3, 0, 1234, 0, 0,          0, 2, 0,    1);
    tbl[17] = mk(4, 4, 5678, 0, 300,        1, 0, 700,  0);
    tbl[18] = mk(3, 5, 0, 0, 0,             0, 3, 0,    0);
    tbl[19] = mk(3, 5, 0, 0, 0,             0, 3, 0,    0);
    tbl[20] = mk(3, 5, 6789, 0, 0,          1, 0, 1000, 0);
    tbl[21] = mk(3, 5, 0, 0, 0,             0, 3, 0,    0);
    tbl[22] = mk(3, 5, 0, 0, 0,             0, 3, 0,    0);
    tbl[23] = mk(3, 5, 6789, 0, 0,          1, 0, 1000, 0);

    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 7);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_success", 32'(success), 0);
    chk("rst_err", 32'(err_code), 0);
    chk("rst_bal", balance, 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_lang", 32'(lang_sel), 0);
    rst = 1'b1;

    // State walk of a balance enquiry, language latched high.
    @(negedge clk);
    drive(mk(3, 1, 2345, 0, 0, 1, 0, 1000, 0), 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (k == 0) scramble();
      st[k] = state;
      if (k == 2) begin
        chk("trace_done", 32'(done), 1);
        if (done) compare_done("trace");
        else void'(sb.pop_front());
      end
    end
    chk("trace_s0", 32'(st[0]), 1);
    chk("trace_s1", 32'(st[1]), 3);
    chk("trace_s2", 32'(st[2]), 0);
    chk("trace_s3", 32'(st[3]), 7);
    chk("trace_lang", 32'(lang_sel), 1);
    chk("trace_ready", 32'(ready), 1);

    for (int i = 0; i < 24; i++) run(tbl[i], $sformatf("vec%0d", i));

    // Lockout and balances clear on reset.
    do_reset();
    run(mk(3, 0, 1234, 0, 0, 1, 0, 1000, 0), "unlock");

    // Reset in the WDR cycle aborts without done or write.
    @(negedge clk);
    drive(mk(4, 1, 2345, 0, 500, 0, 0, 0, 0), 1'b0);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("abort_in_wdr", 32'(state), 4);
    void'(sb.pop_front());
    d0 = done_cnt;
    rst = 1'b0;
    #1;
    chk("abort_state", 32'(state), 7);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    run(mk(3, 1, 2345, 0, 0, 1, 0, 1000, 0), "abort_bal");

    // req held while busy is ignored: exactly one done.
    @(negedge clk);
    d0 = done_cnt;
    drive(mk(3, 5, 6789, 0, 0, 1, 0, 1000, 0), 1'b0);
    @(negedge clk);
    operation = 3'd4; acc_num = 3'd5; pin = 16'd6789;
    amount = 32'd1;
    @(negedge clk);
    req = 1'b0;
    wait_done("busy", lat);
    repeat (6) @(negedge clk);
    chk("busy_one_done", 32'(done_cnt - d0), 1);
    run(mk(3, 5, 6789, 0, 0, 1, 0, 1000, 0), "busy_bal");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=1 required=0");
    $fatal(1, "timeout");
  end

endmodule
